// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and bit-period arithmetic,
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per line bit; integer truncation of the ratio.
    function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and line/status signals between an upstream byte source
// (master) and the UART transmitter (slave).
interface uart_tx_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/en_uart_tx.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and wraps, with a one-cycle tick
// on the final count. restart_i realigns the period to a new frame.
module en_uart_tx #(
    parameter int BIT_CYCLES = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the last count, or realign on restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per frame over a valid/ready handshake
// and shifts start, 8 data bits (LSB first), optional parity and 1-2 stop
// bits onto a registered, idle-high serial line.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | line high, o_ready high, waiting for a byte
//   ST_START  | start bit (line low)
//   ST_DATA   | data bits 0..7, LSB first
//   ST_PARITY | parity bit (only reached when PARITY_EN=1)
//   ST_STOP   | stop bit(s) (line high), o_done on the final cycle
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);
    localparam int   BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    if (!((STOP_BITS == 1) || (STOP_BITS == 2))) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
        $fatal(1, "uart_tx: CLK_FREQ must be at least BAUD_RATE");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        tx_q, tx_d;
    logic        ready_q;
    logic        done;
    logic        tick;
    logic        accept;
    logic        parity_bit;

    assign accept     = bus.i_valid && ready_q;
    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);

    // The bit period starts fresh on the acceptance edge, so the start bit
    // lasts exactly one full period regardless of idle time.
    en_uart_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart_i(accept),
        .tick_o   (tick)
    );

    // Next-state, bit sequencing and line level for the coming cycle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    data_d     = bus.i_data;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        bit_idx_d  = 3'd0;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d    = ST_IDLE;
                        stop_idx_d = 1'b0;
                        done       = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level is decided from the next state so the flop output
        // changes on the same edge as the state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_idx_d];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase
    end

    // State, latched byte, counters and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= (state_d == ST_IDLE);
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_tx    = tx_q;
    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_done  = done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations driven from one clock,
// table-driven frame vectors plus hand sequences for back-to-back frames,
// bytes offered while busy, and mid-frame reset.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       valid [4];
    logic [7:0] data  [4];
    logic       tx    [4];
    logic       ready [4];
    logic       busy  [4];
    logic       done  [4];

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();
    uart_tx_if bus3 ();

    assign bus0.i_valid = valid[0];
    assign bus0.i_data  = data[0];
    assign bus1.i_valid = valid[1];
    assign bus1.i_data  = data[1];
    assign bus2.i_valid = valid[2];
    assign bus2.i_data  = data[2];
    assign bus3.i_valid = valid[3];
    assign bus3.i_data  = data[3];

    assign tx[0] = bus0.o_tx;  assign ready[0] = bus0.o_ready;
    assign busy[0] = bus0.o_busy; assign done[0] = bus0.o_done;
    assign tx[1] = bus1.o_tx;  assign ready[1] = bus1.o_ready;
    assign busy[1] = bus1.o_busy; assign done[1] = bus1.o_done;
    assign tx[2] = bus2.o_tx;  assign ready[2] = bus2.o_ready;
    assign busy[2] = bus2.o_busy; assign done[2] = bus2.o_done;
    assign tx[3] = bus3.o_tx;  assign ready[3] = bus3.o_ready;
    assign busy[3] = bus3.o_busy; assign done[3] = bus3.o_done;

    // 0: defaults (868 clocks/bit); 1: even parity; 2: odd parity;
    // 3: 10 clocks/bit with two stop bits.
    uart_tx u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // seq holds the line level of each bit period in transmit order,
    // period 0 in bit 11.
    typedef struct {
        int          idx;
        logic [7:0]  data;
        logic [11:0] seq;
        int          nbits;
        int          n;
        string       name;
    } vec_t;

    vec_t vecs [6];

    function automatic void check(input bit ok, input string nm, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endfunction

    task automatic accept(input int idx, input logic [7:0] d);
        int w;
        w = 0;
        while (ready[idx] !== 1'b1 && w < 20000) begin
            @(posedge clk); #1;
            w++;
        end
        check(ready[idx] === 1'b1, "ready before offer", int'(ready[idx]), 1);
        valid[idx] = 1'b1;
        data[idx]  = d;
        @(posedge clk); #1;
    endtask

    // Called one step after the acceptance edge; checks every cycle of the frame.
    task automatic check_frame(input int idx, input logic [11:0] seq, input int nbits,
                               input int n, input string nm);
        int   bad;
        int   dbad;
        int   sbad;
        logic e;
        bit   last;
        dbad = 0;
        sbad = 0;
        for (int k = 0; k < nbits; k++) begin
            e   = seq[11-k];
            bad = 0;
            for (int c = 0; c < n; c++) begin
                last = (k == nbits - 1) && (c == n - 1);
                if (tx[idx] !== e) bad++;
                if (done[idx] !== last) dbad++;
                if (busy[idx] !== 1'b1 || ready[idx] !== 1'b0) sbad++;
                @(posedge clk); #1;
            end
            check(bad == 0, $sformatf("%s period%0d cycles off", nm, k), bad, 0);
        end
        check(dbad == 0, $sformatf("%s done placement errors", nm), dbad, 0);
        check(sbad == 0, $sformatf("%s busy/ready errors", nm), sbad, 0);
        check(ready[idx] === 1'b1, $sformatf("%s ready after frame", nm), int'(ready[idx]), 1);
        check(tx[idx] === 1'b1, $sformatf("%s line idle after frame", nm), int'(tx[idx]), 1);
        check(busy[idx] === 1'b0, $sformatf("%s busy after frame", nm), int'(busy[idx]), 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        vecs[0] = '{0, 8'h55, 12'b010101010100, 10, 868, "d0 0x55"};
        vecs[1] = '{1, 8'h07, 12'b011100000110, 11, 868, "even 0x07"};
        vecs[2] = '{2, 8'h07, 12'b011100000010, 11, 868, "odd 0x07"};
        vecs[3] = '{1, 8'h80, 12'b000000001110, 11, 868, "even 0x80"};
        vecs[4] = '{3, 8'h12, 12'b001001000110, 11, 10, "stop2 0x12"};
        vecs[5] = '{3, 8'hFF, 12'b011111111110, 11, 10, "stop2 0xFF"};

        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check(tx[i] === 1'b1, $sformatf("reset tx dut%0d", i), int'(tx[i]), 1);
            check(ready[i] === 1'b0, $sformatf("reset ready dut%0d", i), int'(ready[i]), 0);
            check(busy[i] === 1'b0, $sformatf("reset busy dut%0d", i), int'(busy[i]), 0);
            check(done[i] === 1'b0, $sformatf("reset done dut%0d", i), int'(done[i]), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check(ready[i] === 1'b1, $sformatf("ready after reset dut%0d", i), int'(ready[i]), 1);
        end

        // Table frames; the input byte is scrambled right after acceptance.
        for (int v = 0; v < 6; v++) begin
            accept(vecs[v].idx, vecs[v].data);
            valid[vecs[v].idx] = 1'b0;
            data[vecs[v].idx]  = ~vecs[v].data;
            check_frame(vecs[v].idx, vecs[v].seq, vecs[v].nbits, vecs[v].n, vecs[v].name);
        end

        // Back-to-back: valid held, second byte presented after the first is taken.
        accept(0, 8'hA5);
        data[0] = 8'h3C;
        check_frame(0, 12'b010100101100, 10, 868, "b2b 0xA5");
        @(posedge clk); #1;
        valid[0] = 1'b0;
        data[0]  = 8'h00;
        check_frame(0, 12'b000111100100, 10, 868, "b2b 0x3C");

        // Byte offered during DATA must be ignored.
        accept(0, 8'h12);
        valid[0] = 1'b0;
        fork
            check_frame(0, 12'b001001000100, 10, 868, "ignore 0x12");
            begin
                repeat (868 * 3) @(posedge clk);
                #1;
                valid[0] = 1'b1;
                data[0]  = 8'hFF;
                @(posedge clk); #1;
                valid[0] = 1'b0;
            end
        join
        bad = 0;
        repeat (100) begin
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check(bad == 0, "no frame for ignored 0xFF", bad, 0);

        // Mid-frame reset at clock 3000 of a 0x00 frame.
        accept(0, 8'h00);
        valid[0] = 1'b0;
        bad = 0;
        repeat (2999) begin
            if (done[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check(tx[0] === 1'b0, "abort line low before reset", int'(tx[0]), 0);
        check(busy[0] === 1'b1, "abort busy before reset", int'(busy[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check(tx[0] === 1'b1, "abort tx after reset edge", int'(tx[0]), 1);
        check(busy[0] === 1'b0, "abort busy after reset edge", int'(busy[0]), 0);
        check(ready[0] === 1'b0, "abort ready during reset", int'(ready[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check(ready[0] === 1'b1, "abort ready after release", int'(ready[0]), 1);
        repeat (2 * 868) begin
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check(bad == 0, "abort no done and line idle", bad, 0);

        // Timer and bit index must be clean after the abort.
        accept(0, 8'h55);
        valid[0] = 1'b0;
        check_frame(0, 12'b010101010100, 10, 868, "post-abort 0x55");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
